// File: rtl/decoder_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_stage_pkg
// Description : Shared RV32I decode definitions: major opcode constants
//               (instr[6:2]), immediate format codes, buffer state encoding,
//               the decoded-field record and the opcode -> format selector.
// Revision    : 1.0 - initial registered/parametrised release
// ============================================================================
package decoder_stage_pkg;

  // Major opcodes, instr[6:2] (instr[1:0] == 2'b11 for 32-bit encodings)
  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  // Immediate format selector
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_e;

  // Occupancy of the OUT/SKID pair
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // XLEN-independent decoded fields; PC and immediate are stored alongside
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
  } fields_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [4:0] opcode);
    case (opcode)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_LUI, OP_AUIPC:  return IMM_U;
      OP_JAL:            return IMM_J;
      default:           return IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : decoder_stage_imm_gen
// Description : Combinational immediate generator. Builds the I/S/B/U/J
//               immediate from the instruction and sign-extends from
//               instr[31] to XLEN.
// Ports       : instr_i  in  instr[31:7] (the opcode bits carry no imm data)
//               fmt_i    in  immediate format
//               imm_o    out XLEN-wide sign-extended immediate
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_stage_imm_gen
  import decoder_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_S: imm_o = {{(XLEN-11){instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
      IMM_B: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      IMM_U: imm_o = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
      IMM_J: imm_o = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm_o = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decoder_stage.sv
`default_nettype none
// ============================================================================
// Module      : decoder_stage
// Description : Registered RV32I field decoder with valid/ready handshake and
//               a 2-entry (OUT + SKID) buffer so that O_ready is a register
//               and never depends combinationally on I_ready. Words are
//               decoded before storage; I_flush empties the buffer and drops
//               the word presented in the same cycle.
// Option      : define DECODER_ILLEGAL_EN to compute O_illegal; otherwise it
//               is tied to 0 and the check logic is absent.
// Ports       : I_clk, I_reset (async, active-high)
//               I_instr/I_pc/I_valid/O_ready  upstream word + handshake
//               I_flush                       discard held and incoming words
//               O_valid/I_ready               downstream handshake
//               O_pc, O_rs1, O_rs2, O_rd, O_opcode, O_funct3, O_funct7,
//               O_imm, O_illegal              decoded word
// Revision    : 1.0 - initial registered/parametrised release
// ============================================================================
module decoder_stage
  import decoder_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            I_clk,
  input  logic            I_reset,
  input  logic [31:0]     I_instr,
  input  logic [XLEN-1:0] I_pc,
  input  logic            I_valid,
  output logic            O_ready,
  input  logic            I_flush,
  output logic            O_valid,
  input  logic            I_ready,
  output logic [XLEN-1:0] O_pc,
  output logic [4:0]      O_rs1,
  output logic [4:0]      O_rs2,
  output logic [4:0]      O_rd,
  output logic [4:0]      O_opcode,
  output logic [2:0]      O_funct3,
  output logic [6:0]      O_funct7,
  output logic [XLEN-1:0] O_imm,
  output logic            O_illegal
);

  // --------------------------------------------------------------------------
  // Decode (ahead of the buffer)
  // --------------------------------------------------------------------------
  fields_t         dec_fields;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  assign dec_fmt = imm_fmt_of(I_instr[6:2]);

  decoder_stage_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr_i (I_instr[31:7]),
    .fmt_i   (dec_fmt),
    .imm_o   (dec_imm)
  );

`ifdef DECODER_ILLEGAL_EN
  always_comb begin
    dec_illegal = (I_instr[1:0] != 2'b11);
    case (I_instr[6:2])
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC,
      OP_MISC_MEM, OP_SYSTEM: ;
      OP_JALR:
        if (I_instr[14:12] != 3'b000) dec_illegal = 1'b1;
      OP_OP:
        if (I_instr[31:25] != 7'b0000000 && I_instr[31:25] != 7'b0100000)
          dec_illegal = 1'b1;
      OP_OP_IMM: begin
        // RV64 shifts borrow instr[25] as shamt[5], so only [31:26] is funct
        if (I_instr[14:12] == 3'b001) begin
          if (XLEN == 64) begin
            if (I_instr[31:26] != 6'b000000) dec_illegal = 1'b1;
          end else begin
            if (I_instr[31:25] != 7'b0000000) dec_illegal = 1'b1;
          end
        end else if (I_instr[14:12] == 3'b101) begin
          if (XLEN == 64) begin
            if (I_instr[31:26] != 6'b000000 && I_instr[31:26] != 6'b010000)
              dec_illegal = 1'b1;
          end else begin
            if (I_instr[31:25] != 7'b0000000 && I_instr[31:25] != 7'b0100000)
              dec_illegal = 1'b1;
          end
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end
`else
  logic unused_instr_lsbs;
  assign dec_illegal       = 1'b0;
  assign unused_instr_lsbs = ^I_instr[1:0];
`endif

  always_comb begin
    dec_fields         = '0;
    dec_fields.rs1     = I_instr[19:15];
    dec_fields.rs2     = I_instr[24:20];
    dec_fields.rd      = I_instr[11:7];
    dec_fields.opcode  = I_instr[6:2];
    dec_fields.funct3  = I_instr[14:12];
    dec_fields.funct7  = I_instr[31:25];
    dec_fields.illegal = dec_illegal;
  end

  // --------------------------------------------------------------------------
  // Buffer control
  // --------------------------------------------------------------------------
  buf_state_e state_q, state_d;
  logic       ready_q;
  logic       in_fire, out_fire;
  logic       load_out_in, load_out_skid, load_skid_in;

  assign O_valid  = (state_q != BUF_EMPTY);
  assign O_ready  = ready_q;
  assign in_fire  = I_valid && ready_q;
  assign out_fire = O_valid && I_ready;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      // Registered ready: next cycle SKID is free unless we end up FULL
      ready_q <= (state_d != BUF_FULL);
    end
  end

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid_in  = 1'b0;
    if (I_flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_fire) begin
            state_d     = BUF_ONE;
            load_out_in = 1'b1;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            load_out_in = 1'b1;
          end else if (in_fire) begin
            state_d      = BUF_FULL;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          // ready_q is low here, so no input can arrive
          if (out_fire) begin
            state_d       = BUF_ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Buffer storage
  // --------------------------------------------------------------------------
  fields_t         out_q, skid_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q;
  logic [XLEN-1:0] out_imm_q, skid_imm_q;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      out_q      <= '0;
      out_pc_q   <= PC_RESET;
      out_imm_q  <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
      skid_imm_q <= '0;
    end else begin
      if (load_out_in) begin
        out_q     <= dec_fields;
        out_pc_q  <= I_pc;
        out_imm_q <= dec_imm;
      end else if (load_out_skid) begin
        out_q     <= skid_q;
        out_pc_q  <= skid_pc_q;
        out_imm_q <= skid_imm_q;
      end
      if (load_skid_in) begin
        skid_q     <= dec_fields;
        skid_pc_q  <= I_pc;
        skid_imm_q <= dec_imm;
      end
    end
  end

  assign O_pc      = out_pc_q;
  assign O_rs1     = out_q.rs1;
  assign O_rs2     = out_q.rs2;
  assign O_rd      = out_q.rd;
  assign O_opcode  = out_q.opcode;
  assign O_funct3  = out_q.funct3;
  assign O_funct7  = out_q.funct7;
  assign O_imm     = out_imm_q;
  assign O_illegal = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decoder_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_stage
// Description : Bench for decoder_stage. Drives an XLEN=32 and an XLEN=64
//               instance from the same stimulus and compares both against a
//               reference: a 2-deep FIFO of accepted words whose fields and
//               immediates are computed from the instruction encoding rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_stage;

  localparam logic [31:0] PC_RST32 = 32'h0000_1000;
  localparam logic [63:0] PC_RST64 = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        vld, rdy, flush;

  logic        ready32, valid32, ill32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rs1_32, rs2_32, rd_32, opc32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;

  logic        ready64, valid64, ill64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rs1_64, rs2_64, rd_64, opc64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;

  always #5 clk = ~clk;

  decoder_stage #(.XLEN(32), .PC_RESET(PC_RST32)) dut32 (
    .I_clk(clk), .I_reset(rst), .I_instr(instr), .I_pc(pc[31:0]),
    .I_valid(vld), .O_ready(ready32), .I_flush(flush), .O_valid(valid32),
    .I_ready(rdy), .O_pc(pc32), .O_rs1(rs1_32), .O_rs2(rs2_32), .O_rd(rd_32),
    .O_opcode(opc32), .O_funct3(f3_32), .O_funct7(f7_32), .O_imm(imm32),
    .O_illegal(ill32)
  );

  decoder_stage #(.XLEN(64), .PC_RESET(PC_RST64)) dut64 (
    .I_clk(clk), .I_reset(rst), .I_instr(instr), .I_pc(pc),
    .I_valid(vld), .O_ready(ready64), .I_flush(flush), .O_valid(valid64),
    .I_ready(rdy), .O_pc(pc64), .O_rs1(rs1_64), .O_rs2(rs2_64), .O_rd(rd_64),
    .O_opcode(opc64), .O_funct3(f3_64), .O_funct7(f7_64), .O_imm(imm64),
    .O_illegal(ill64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } txn_t;

  txn_t q[$];
  bit   m_ready;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] sh;
    sh = v << (64 - bits);
    return 64'($signed(sh) >>> (64 - bits));
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] i);
    case (i[6:2])
      5'b01000:          return sext(64'({i[31:25], i[11:7]}), 12);
      5'b11000:          return sext(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
      5'b01101, 5'b00101: return sext(64'({i[31:12], 12'b0}), 32);
      5'b11011:          return sext(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
      default:           return sext(64'(i[31:20]), 12);
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i, input int xlen);
    logic bad;
    bad = 1'b0;
`ifdef DECODER_ILLEGAL_EN
    if (i[1:0] != 2'b11) bad = 1'b1;
    if (!(i[6:2] inside {5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
                         5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b00011,
                         5'b11100})) bad = 1'b1;
    if (i[6:2] == 5'b01100 && !(i[31:25] inside {7'h00, 7'h20})) bad = 1'b1;
    if (i[6:2] == 5'b11001 && i[14:12] != 3'b000) bad = 1'b1;
    if (i[6:2] == 5'b00100 && i[14:12] == 3'b001)
      bad = bad | ((xlen == 64) ? (i[31:26] != 6'h00) : (i[31:25] != 7'h00));
    if (i[6:2] == 5'b00100 && i[14:12] == 3'b101)
      bad = bad | ((xlen == 64) ? !(i[31:26] inside {6'h00, 6'h10})
                                : !(i[31:25] inside {7'h00, 7'h20}));
`endif
    return bad;
  endfunction

  task automatic check_outputs();
    txn_t t;
    logic [63:0] e_imm;
    check("valid32", 64'(valid32), 64'(q.size() != 0));
    check("valid64", 64'(valid64), 64'(q.size() != 0));
    check("ready32", 64'(ready32), 64'(m_ready));
    check("ready64", 64'(ready64), 64'(m_ready));
    if (q.size() != 0) begin
      t = q[0];
      e_imm = ref_imm(t.instr);
      check("pc32", 64'(pc32), 64'(t.pc[31:0]));
      check("pc64", pc64, t.pc);
      check("rs1", 64'(rs1_32), 64'(t.instr[19:15]));
      check("rs2", 64'(rs2_32), 64'(t.instr[24:20]));
      check("rd", 64'(rd_32), 64'(t.instr[11:7]));
      check("opcode", 64'(opc32), 64'(t.instr[6:2]));
      check("funct3", 64'(f3_32), 64'(t.instr[14:12]));
      check("funct7", 64'(f7_32), 64'(t.instr[31:25]));
      check("rd64", 64'(rd_64), 64'(t.instr[11:7]));
      check("imm32", 64'(imm32), 64'(e_imm[31:0]));
      check("imm64", imm64, e_imm);
      check("illegal32", 64'(ill32), 64'(ref_illegal(t.instr, 32)));
      check("illegal64", 64'(ill64), 64'(ref_illegal(t.instr, 64)));
    end
  endtask

  // One clock: drive inputs, advance the reference at the edge, check after
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] p,
                      input bit r, input bit f);
    bit in_fire, out_fire;
    vld = v; instr = ins; pc = p; rdy = r; flush = f;
    @(posedge clk);
    in_fire  = v && m_ready;
    out_fire = (q.size() != 0) && r;
    if (f) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back('{ins, p});
    end
    m_ready = (q.size() < 2);
    @(negedge clk);
    check_outputs();
  endtask

  localparam logic [31:0] ADDI = 32'hFFF10093;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] JAL  = 32'h001000EF;
  localparam logic [31:0] LUI  = 32'h800000B7;
  localparam logic [31:0] SW   = 32'h00512423;

  logic [4:0]  opcs [11] = '{5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
                             5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b00011,
                             5'b11100};
  logic [31:0] rins;

  initial begin
    rst = 1'b1; vld = 1'b0; instr = '0; pc = '0; rdy = 1'b0; flush = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", 64'(valid32), 64'd0);
    check("rst_ready", 64'(ready32), 64'd1);
    check("rst_pc32", 64'(pc32), 64'(PC_RST32));
    check("rst_pc64", pc64, PC_RST64);
    check("rst_imm", 64'(imm32), 64'd0);
    check("rst_rd", 64'(rd_32), 64'd0);
    check("rst_illegal", 64'(ill32), 64'd0);
    rst = 1'b0;

    // addi x1,x2,-1
    step(1, ADDI, 64'h100, 1, 0);
    check("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
    check("addi_rd", 64'(rd_32), 64'd1);
    check("addi_rs1", 64'(rs1_32), 64'd2);
    step(0, '0, '0, 1, 0);

    // Back-to-back branch then jal
    step(1, BEQ, 64'h104, 1, 0);
    check("beq_imm", 64'(imm32), 64'hFFFF_FFFC);
    step(1, JAL, 64'h108, 1, 0);
    check("jal_imm", 64'(imm32), 64'h0000_0800);
    step(1, LUI, 64'h10C, 1, 0);
    check("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    step(0, '0, '0, 1, 0);

    // Backpressure: sw then addi with I_ready low
    step(1, SW, 64'h200, 0, 0);
    check("sw_imm", 64'(imm32), 64'd8);
    step(1, ADDI, 64'h204, 0, 0);
    check("bp_hold_imm", 64'(imm32), 64'd8);
    check("bp_ready_low", 64'(ready32), 64'd0);
    step(0, '0, '0, 1, 0);
    check("bp_second", 64'(imm32), 64'hFFFF_FFFF);
    step(0, '0, '0, 1, 0);

    // Flush while FULL with a word presented in the same cycle
    step(1, SW, 64'h300, 0, 0);
    step(1, ADDI, 64'h304, 0, 0);
    step(1, LUI, 64'h308, 1, 1);
    check("flush_valid", 64'(valid32), 64'd0);
    check("flush_ready", 64'(ready32), 64'd1);
    repeat (3) step(0, '0, '0, 1, 0);

    // Illegal flag on an all-zero word
    step(1, 32'h0000_0000, 64'h400, 1, 0);
`ifdef DECODER_ILLEGAL_EN
    check("zero_illegal", 64'(ill32), 64'd1);
`else
    check("zero_illegal", 64'(ill32), 64'd0);
`endif
    step(1, ADDI, 64'h404, 1, 0);
    check("addi_legal", 64'(ill32), 64'd0);

    // Asynchronous reset mid-cycle while holding a word
    step(1, SW, 64'h500, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid32), 64'd0);
    check("arst_ready", 64'(ready32), 64'd1);
    check("arst_pc", pc64, PC_RST64);
    q.delete();
    m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1, JAL, 64'h600, 1, 0);
    check("arst_first_accept", 64'(valid32), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rins = $urandom;
      if ($urandom_range(3) != 0) begin
        rins[6:2] = opcs[$urandom_range(10)];
        rins[1:0] = 2'b11;
      end
      step(($urandom_range(9) < 7), rins, {$urandom, $urandom},
           ($urandom_range(9) < 6), ($urandom_range(39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
